// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the EX-stage ALU control: gout values, funct codes, mul/div FSM states.
package alu_ctrl_pkg;

  localparam logic [2:0] GOUT_ADD  = 3'b010;
  localparam logic [2:0] GOUT_SUB  = 3'b110;
  localparam logic [2:0] GOUT_AND  = 3'b000;
  localparam logic [2:0] GOUT_OR   = 3'b001;
  localparam logic [2:0] GOUT_NOR  = 3'b100;
  localparam logic [2:0] GOUT_SLT  = 3'b111;
  localparam logic [2:0] GOUT_X011 = 3'b011;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

  // aluop 11 decodes like R-type.
  function automatic logic [2:0] gout_dec(input logic [1:0] aluop, input logic [3:0] fn);
    logic [2:0] g;
    g = GOUT_ADD;
    if (aluop == 2'b01) g = GOUT_SUB;
    else if (aluop[1]) begin
      case (fn)
        4'b0000: g = GOUT_ADD;
        4'b0010: g = GOUT_SUB;
        4'b0100: g = GOUT_AND;
        4'b0101: g = GOUT_OR;
        4'b0111: g = GOUT_NOR;
        4'b1010: g = GOUT_SLT;
        4'b1111: g = GOUT_X011;
        default: g = GOUT_ADD;
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative multiply/divide datapath on operand magnitudes; sign correction is combinational
// on the outputs so the controller can capture the final HI/LO at the FIX exit edge.
module muldiv_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0]   r_hi, r_lo, r_mc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div, r_neg_q, r_neg_r, r_dz;

  logic [WIDTH-1:0]   w_ma, w_mb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod_n;

  assign w_ma = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_mb = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // Shift-add: multiplier sits in r_lo, partial product grows down from r_hi.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);

  // Restoring divide: remainder in r_hi, dividend shifts out of r_lo as quotient shifts in.
  assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_mc});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_mc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_mc    <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (load) begin
      r_cnt   <= CNT_W'(WIDTH);
      r_div   <= is_div;
      r_neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r <= is_signed & a[WIDTH-1];
      r_dz    <= is_div & (b == '0);
      if (is_div && b == '0) begin
        r_hi <= a;
        r_lo <= '1;
        r_mc <= '0;
      end else if (is_div) begin
        r_hi <= '0;
        r_lo <= w_ma;
        r_mc <= w_mb;
      end else begin
        r_hi <= '0;
        r_lo <= w_mb;
        r_mc <= w_ma;
      end
    end else if (step) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_div) begin
        r_hi <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], w_ge};
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign w_prod_n = ~{r_hi, r_lo} + (2*WIDTH)'(1);

  // Magnitudes are unsigned, so negating MIN wraps back to MIN exactly.
  always_comb begin
    res_hi = r_hi;
    res_lo = r_lo;
    if (!r_dz) begin
      if (r_div) begin
        if (r_neg_q) res_lo = ~r_lo + WIDTH'(1);
        if (r_neg_r) res_hi = ~r_hi + WIDTH'(1);
      end else if (r_neg_q) begin
        {res_hi, res_lo} = w_prod_n;
      end
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control: gout decode, mul/div sequencing FSM, HI/LO registers,
// and the HI/LO hazard stall plus mfhi/mflo read path.
module alu_muldiv_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       gout,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mf_valid,
  output logic [WIDTH-1:0] mf_data
);

  md_state_t        r_state, w_nxt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;

  logic             w_is_md, w_is_mf, w_is_div, w_signed, w_is_mfhi;
  logic             w_load, w_step, w_wr;
  logic [CNT_W-1:0] w_cnt;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  assign gout = gout_dec(aluop, funct[3:0]);

  assign w_is_div  = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign w_signed  = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign w_is_md   = aluop[1] && (w_is_div || funct == FUNCT_MULT || funct == FUNCT_MULTU);
  assign w_is_mfhi = aluop[1] && (funct == FUNCT_MFHI);
  assign w_is_mf   = w_is_mfhi || (aluop[1] && funct == FUNCT_MFLO);

  muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .step      (w_step),
    .is_div    (w_is_div),
    .is_signed (w_signed),
    .a         (a),
    .b         (b),
    .cnt       (w_cnt),
    .res_hi    (w_res_hi),
    .res_lo    (w_res_lo)
  );

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && w_is_md && !flush) begin
          w_load = 1'b1;
          // Divide by zero needs no iterations; its result is set up at load.
          w_nxt  = (w_is_div && b == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (flush) w_nxt = IDLE;
        else begin
          w_step = 1'b1;
          if (w_cnt == CNT_W'(1)) w_nxt = FIX;
        end
      end
      FIX: begin
        w_nxt = IDLE;
        w_wr  = !flush;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_wr;
      if (w_wr) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign stall    = start && busy && (w_is_md || w_is_mf);
  assign mf_valid = start && w_is_mf && !stall;
  assign mf_data  = w_is_mfhi ? r_hi : (w_is_mf ? r_lo : '0);

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl: decode table, mul/div results and latency,
// HI/LO hazard stall, flush and asynchronous reset.
module tb_alu_muldiv_ctrl;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011, F_MFHI = 6'b010000;

  logic        clk, rst_n, start, flush;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic [2:0]  gout;
  logic        busy, done, stall, mf_valid;
  logic [31:0] hi, lo, mf_data;

  int checks = 0;
  int errors = 0;

  alu_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct), .start(start), .flush(flush),
    .a(a), .b(b), .gout(gout), .busy(busy), .done(done), .stall(stall),
    .hi(hi), .lo(lo), .mf_valid(mf_valid), .mf_data(mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; flush = 1'b0; aluop = 2'b10; funct = F_MFHI; a = '0; b = '0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h exp 0 0 0 0", busy, done, hi, lo);
    end
    checks++;
    if (stall !== 1'b0 || mf_data !== 32'h0 || mf_valid !== 1'b1) begin
      errors++; $display("FAIL reset_comb: stall=%b mf_data=%h mf_valid=%b exp 0 0 1", stall, mf_data, mf_valid);
    end
    start = 1'b0; funct = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [2:0] exp_g [16] = '{3'b010, 3'b010, 3'b110, 3'b010, 3'b000, 3'b001, 3'b010, 3'b100,
                               3'b010, 3'b010, 3'b111, 3'b010, 3'b010, 3'b010, 3'b010, 3'b011};
    aluop = 2'b10;
    for (int i = 0; i < 16; i++) begin
      funct = {2'b10, 4'(i)};
      #1;
      checks++;
      if (gout !== exp_g[i]) begin
        errors++; $display("FAIL decode_rtype f=%0d: got %b exp %b", i, gout, exp_g[i]);
      end
    end
    funct = 6'b100111;
    aluop = 2'b00; #1; checks++;
    if (gout !== 3'b010) begin errors++; $display("FAIL decode_aluop00: got %b exp 010", gout); end
    aluop = 2'b01; #1; checks++;
    if (gout !== 3'b110) begin errors++; $display("FAIL decode_aluop01: got %b exp 110", gout); end
    aluop = 2'b11; #1; checks++;
    if (gout !== 3'b100) begin errors++; $display("FAIL decode_aluop11: got %b exp 100", gout); end
    aluop = 2'b10; funct = '0;
    tick();
  endtask

  // Issue one mul/div op from IDLE and follow it cycle by cycle to the done pulse.
  task automatic run_md(input string nm, input logic [5:0] f, input logic [31:0] ta,
                        input logic [31:0] tb, input int lat,
                        input logic [31:0] eh, input logic [31:0] el);
    int bad;
    aluop = 2'b10; funct = f; a = ta; b = tb; start = 1'b1;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL %s_accept_stall: got %b exp 0", nm, stall); end
    tick();
    start = 1'b0; funct = '0;
    bad = 0;
    for (int k = 1; k < lat; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) begin
        if (bad == 0) $display("FAIL %s_busy cycle %0d: busy=%b done=%b exp 1 0", nm, k, busy, done);
        bad++;
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done cycle %0d: done=%b busy=%b exp 1 0", nm, lat, done, busy);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++; $display("FAIL %s_result: hi=%h lo=%h exp %h %h", nm, hi, lo, eh, el);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: done=%b exp 0", nm, done); end
  endtask

  task automatic test_mult();
    run_md("mult",     F_MULT,  32'hFFFFFFFD, 32'd7,        34, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu",    F_MULTU, 32'hFFFFFFFD, 32'd7,        34, 32'h00000006, 32'hFFFFFFEB);
    run_md("mult_min", F_MULT,  32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000);
  endtask

  task automatic test_div();
    run_md("div_neg",   F_DIV,  32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_mixed", F_DIV,  32'd7,        32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD);
    run_md("div_min",   F_DIV,  32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000);
    run_md("divu",      F_DIVU, 32'd100,      32'd7,        34, 32'h00000002, 32'h0000000E);
    run_md("divu_zero", F_DIVU, 32'd5,        32'd0,        2,  32'h00000005, 32'hFFFFFFFF);
    run_md("div_zero",  F_DIV,  32'hFFFFFFFB, 32'd0,        2,  32'hFFFFFFFB, 32'hFFFFFFFF);
  endtask

  task automatic test_hazard();
    int bad;
    aluop = 2'b10; funct = F_MULT; a = 32'h00010000; b = 32'h00030000; start = 1'b1;
    tick();
    start = 1'b0; funct = '0;
    tick(); tick();
    start = 1'b1; funct = F_MFHI;
    bad = 0;
    for (int k = 3; k <= 33; k++) begin
      #1;
      if (stall !== 1'b1 || mf_valid !== 1'b0) begin
        if (bad == 0) $display("FAIL hazard_stall cycle %0d: stall=%b mf_valid=%b exp 1 0", k, stall, mf_valid);
        bad++;
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    #1; checks++;
    if (stall !== 1'b0 || mf_valid !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL hazard_release: stall=%b mf_valid=%b done=%b exp 0 1 1", stall, mf_valid, done);
    end
    checks++;
    if (mf_data !== 32'h00000003) begin
      errors++; $display("FAIL hazard_mfhi_data: got %h exp 00000003", mf_data);
    end
    start = 1'b0; funct = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int bad;
    aluop = 2'b10; funct = F_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0; funct = '0;
    for (int k = 1; k < 34; k++) tick();
    checks++;
    if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'h0000001E) begin
      errors++; $display("FAIL b2b_first: done=%b hi=%h lo=%h exp 1 00000000 0000001e", done, hi, lo);
    end
    funct = F_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b exp 0", stall); end
    tick();
    start = 1'b0; funct = '0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b exp 1", busy); end
    bad = 0;
    for (int k = 1; k < 34; k++) begin
      if (done !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || done !== 1'b1 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL b2b_second: done=%b hi=%h lo=%h early=%0d exp 1 fffffffe 00000001 0", done, hi, lo, bad);
    end
    tick();
  endtask

  task automatic test_flush();
    int seen;
    aluop = 2'b10; funct = F_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; funct = '0;
    for (int k = 1; k < 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: busy=%b exp 0", busy); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_done: done cycles=%0d exp 0", seen); end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL flush_hilo: hi=%h lo=%h exp fffffffe 00000001", hi, lo);
    end
    funct = F_MULT; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0; funct = '0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_idle: busy=%b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    aluop = 2'b10; funct = F_MULT; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; funct = '0;
    for (int k = 0; k < 5; k++) tick();
    #2 rst_n = 1'b0;
    #1; checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h exp 0 0 0 0", busy, done, hi, lo);
    end
    start = 1'b1; funct = F_MFHI;
    #1; checks++;
    if (stall !== 1'b0 || mf_data !== 32'h0) begin
      errors++; $display("FAIL async_reset_comb: stall=%b mf_data=%h exp 0 0", stall, mf_data);
    end
    start = 1'b0; funct = '0;
    tick();
    rst_n = 1'b1;
    tick();
    run_md("post_reset", F_MULT, 32'd2, 32'd3, 34, 32'h0, 32'h6);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_hazard();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
